// File: rtl/sdfm_pkg.sv
// rtl/sdfm_pkg.sv - shared mode encodings and Manchester FSM states for the sigma-delta front end
package sdfm_pkg;

   localparam logic [1:0] MOD_RISE  = 2'b00;
   localparam logic [1:0] MOD_FALL  = 2'b01;
   localparam logic [1:0] MOD_MANCH = 2'b10;
   localparam logic [1:0] MOD_BOTH  = 2'b11;

   typedef enum logic {
      ACQ  = 1'b0,
      LOCK = 1'b1
   } man_state_t;

endpackage

// File: rtl/sd_sync.sv
// rtl/sd_sync.sv - multi-flop pin synchronizer with one extra flop for edge detection
module sd_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic pin,
   output logic sync,
   output logic toggle
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], pin};
         prev  <= chain[STAGES-1];
      end
   end

   // toggle marks either polarity; the level in sync tells rise from fall
   assign sync   = chain[STAGES-1];
   assign toggle = chain[STAGES-1] ^ prev;

endmodule

// File: rtl/sd_input_ctrl.sv
// rtl/sd_input_ctrl.sv - sigma-delta pin front end: sample-point select, Manchester decode, clock-loss flag
module sd_input_ctrl
   import sdfm_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 10
) (
   input  logic       SYSCLK,
   input  logic       SYSRSTn,
   input  logic       sd_d_pin,
   input  logic       sd_c_pin,
   input  logic       reg_en,
   input  logic [1:0] reg_mod,
   input  logic [7:0] reg_manper,
   input  logic [7:0] reg_clkto,
   input  logic       clkfail_clr,
   output logic       sd_dsd_in,
   output logic       sd_clk_in,
   output logic       clk_fail,
   output logic       manch_lock
);

   logic             d_sync, d_toggle, c_sync, c_toggle;
   logic             c_rise, c_fall, mod_chg;
   logic [1:0]       mod_q;
   man_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc, tcnt, tcnt_nxt, tcnt_inc;
   logic [CNT_W-1:0] per, thr_long, thr_lost;
   logic             strobe, data_nxt, fail_set;

   sd_sync #(.STAGES(SYNC_STAGES)) u_sync_d (
      .clk(SYSCLK), .resetn(SYSRSTn), .pin(sd_d_pin), .sync(d_sync), .toggle(d_toggle)
   );

   sd_sync #(.STAGES(SYNC_STAGES)) u_sync_c (
      .clk(SYSCLK), .resetn(SYSRSTn), .pin(sd_c_pin), .sync(c_sync), .toggle(c_toggle)
   );

   assign c_rise   = c_toggle & c_sync;
   assign c_fall   = c_toggle & ~c_sync;
   assign mod_chg  = (reg_mod != mod_q);
   assign per      = CNT_W'(reg_manper);
   assign thr_long = per - (per >> 2);
   assign thr_lost = per + (per >> 1);
   assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
   assign tcnt_inc = (tcnt == '1) ? tcnt : tcnt + CNT_W'(1);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tcnt_nxt  = tcnt;
      strobe    = 1'b0;
      data_nxt  = sd_dsd_in;
      fail_set  = 1'b0;
      if (!reg_en) begin
         state_nxt = ACQ;
         cnt_nxt   = '0;
         tcnt_nxt  = '0;
         data_nxt  = 1'b0;
      end else if (mod_chg) begin
         state_nxt = ACQ;
         cnt_nxt   = '0;
         tcnt_nxt  = '0;
      end else if (reg_mod == MOD_MANCH) begin
         tcnt_nxt = '0;
         cnt_nxt  = cnt_inc;
         // a long gap before a transition marks it as mid-bit in both states
         if (d_toggle && (cnt >= thr_long)) begin
            strobe    = 1'b1;
            data_nxt  = d_sync;
            cnt_nxt   = '0;
            state_nxt = LOCK;
         end else if (state == ACQ) begin
            if (d_toggle)
               cnt_nxt = '0;
         end else if (cnt_inc >= thr_lost) begin
            state_nxt = ACQ;
            fail_set  = 1'b1;
         end
      end else begin
         case (reg_mod)
            MOD_RISE: strobe = c_rise;
            MOD_FALL: strobe = c_fall;
            default:  strobe = c_toggle;
         endcase
         if (strobe)
            data_nxt = d_sync;
         if (c_toggle) begin
            tcnt_nxt = '0;
         end else begin
            tcnt_nxt = tcnt_inc;
            // equality gives a single set event, so a clear afterwards sticks
            if ((reg_clkto != 8'd0) && (tcnt_inc == CNT_W'(reg_clkto)))
               fail_set = 1'b1;
         end
      end
   end

   always_ff @(posedge SYSCLK) begin
      if (!SYSRSTn) begin
         state      <= ACQ;
         cnt        <= '0;
         tcnt       <= '0;
         mod_q      <= 2'b00;
         sd_clk_in  <= 1'b0;
         sd_dsd_in  <= 1'b0;
         clk_fail   <= 1'b0;
         manch_lock <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         tcnt       <= tcnt_nxt;
         mod_q      <= reg_mod;
         sd_clk_in  <= strobe;
         sd_dsd_in  <= data_nxt;
         manch_lock <= (state_nxt == LOCK);
         clk_fail   <= fail_set | (clk_fail & ~clkfail_clr);
      end
   end

endmodule

// File: tb/tb_sd_input_ctrl.sv
// tb/tb_sd_input_ctrl.sv - directed self-checking bench with a strobe scoreboard for sd_input_ctrl
module tb_sd_input_ctrl;
   import sdfm_pkg::*;

   logic       SYSCLK = 1'b0;
   logic       SYSRSTn, sd_d_pin, sd_c_pin, reg_en, clkfail_clr;
   logic [1:0] reg_mod;
   logic [7:0] reg_manper, reg_clkto;
   logic       sd_dsd_in, sd_clk_in, clk_fail, manch_lock;

   typedef struct {
      logic d;
      int   cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   compared = 0;
   int   mismatched = 0;
   int   mid = 0;

   always #5 SYSCLK = ~SYSCLK;
   always @(posedge SYSCLK) cyc <= cyc + 1;

   sd_input_ctrl #(.SYNC_STAGES(2), .CNT_W(10)) dut (
      .SYSCLK(SYSCLK), .SYSRSTn(SYSRSTn), .sd_d_pin(sd_d_pin), .sd_c_pin(sd_c_pin),
      .reg_en(reg_en), .reg_mod(reg_mod), .reg_manper(reg_manper), .reg_clkto(reg_clkto),
      .clkfail_clr(clkfail_clr), .sd_dsd_in(sd_dsd_in), .sd_clk_in(sd_clk_in),
      .clk_fail(clk_fail), .manch_lock(manch_lock)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge SYSCLK);
   endtask

   // strobe expected 3 edges after the drive point: capture, sync, output register
   task automatic push(input logic d);
      exp_t e;
      if (reg_en) begin
         e.d   = d;
         e.cyc = cyc + 3;
         q.push_back(e);
      end
   endtask

   task automatic sd_bit(input logic d);
      if (sd_c_pin) begin
         sd_c_pin = 1'b0;
         if (reg_mod == MOD_FALL || reg_mod == MOD_BOTH) push(sd_d_pin);
      end
      idle(2);
      sd_d_pin = d;
      idle(3);
      sd_c_pin = 1'b1;
      if (reg_mod == MOD_RISE || reg_mod == MOD_BOTH) push(sd_d_pin);
      idle(5);
   endtask

   task automatic manch_bit(input logic b);
      sd_d_pin = ~b;
      idle(8);
      sd_d_pin = b;
      push(b);
      mid = cyc;
      idle(8);
   endtask

   always @(negedge SYSCLK) begin
      if (sd_clk_in === 1'b1) begin
         chk("strobe_expected", q.size() != 0, 1'b1);
         if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk("strobe_data", sd_dsd_in, mon_e.d);
            chk("strobe_cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      SYSRSTn = 1'b0; sd_d_pin = 1'b0; sd_c_pin = 1'b0; reg_en = 1'b0; clkfail_clr = 1'b0;
      reg_mod = MOD_RISE; reg_manper = 8'd16; reg_clkto = 8'd0;
      idle(3);
      chk("rst_clk_in", sd_clk_in, 1'b0);
      chk("rst_dsd_in", sd_dsd_in, 1'b0);
      chk("rst_clk_fail", clk_fail, 1'b0);
      chk("rst_manch_lock", manch_lock, 1'b0);
      SYSRSTn = 1'b1; reg_en = 1'b1;
      idle(5);

      sd_bit(1'b1); sd_bit(1'b0); sd_bit(1'b1); sd_bit(1'b1);

      reg_mod = MOD_BOTH;
      idle(3);
      sd_bit(1'b1); sd_bit(1'b0); sd_bit(1'b1); sd_bit(1'b1);

      reg_mod = MOD_FALL;
      idle(3);
      sd_bit(1'b0); sd_bit(1'b1); sd_bit(1'b1); sd_bit(1'b0);

      reg_mod = MOD_RISE; reg_clkto = 8'd20;
      idle(2);
      chk("to_pre_fail", clk_fail, 1'b0);
      sd_c_pin = 1'b0;
      idle(22);
      chk("to_before_hit", clk_fail, 1'b0);
      idle(1);
      chk("to_at_hit", clk_fail, 1'b1);
      clkfail_clr = 1'b1; idle(1); clkfail_clr = 1'b0;
      chk("to_clr_alone", clk_fail, 1'b0);
      sd_c_pin = 1'b1;
      push(sd_d_pin);
      idle(22);
      clkfail_clr = 1'b1; idle(1); clkfail_clr = 1'b0;
      chk("to_set_dominates", clk_fail, 1'b1);
      clkfail_clr = 1'b1; idle(1); clkfail_clr = 1'b0;
      chk("to_clr_again", clk_fail, 1'b0);
      reg_clkto = 8'd0;

      reg_mod = MOD_MANCH; reg_manper = 8'd16;
      idle(20);
      chk("man_unlocked", manch_lock, 1'b0);
      manch_bit(1'b1);
      chk("man_locked", manch_lock, 1'b1);
      manch_bit(1'b0); manch_bit(1'b0); manch_bit(1'b1);
      idle(18);
      chk("lost_lock_before", manch_lock, 1'b1);
      chk("lost_fail_before", clk_fail, 1'b0);
      idle(1);
      chk("lost_lock_after", manch_lock, 1'b0);
      chk("lost_fail_after", clk_fail, 1'b1);

      reg_mod = MOD_RISE;
      idle(3);
      sd_bit(1'b1);
      SYSRSTn = 1'b0;
      idle(1);
      chk("mid_rst_clk_in", sd_clk_in, 1'b0);
      chk("mid_rst_dsd_in", sd_dsd_in, 1'b0);
      chk("mid_rst_clk_fail", clk_fail, 1'b0);
      chk("mid_rst_lock", manch_lock, 1'b0);
      SYSRSTn = 1'b1;
      if (sd_c_pin) push(sd_d_pin);
      idle(2);
      sd_bit(1'b1);
      reg_en = 1'b0;
      idle(1);
      chk("dis_dsd_in", sd_dsd_in, 1'b0);
      chk("dis_clk_in", sd_clk_in, 1'b0);
      sd_bit(1'b0); sd_bit(1'b1);
      idle(5);
      chk("dis_lock", manch_lock, 1'b0);
      chk("dis_clk_fail", clk_fail, 1'b0);
      chk("queue_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
